// File: rtl/nn_pkg.sv
// Shared constants, layer codes and per-layer geometry for the pooling engine.
// No logic, no latency; constants only.
// No flow control here.
package nn_pkg;

    localparam int DAT_W = 22;

    localparam logic [3:0] ST_POOL1 = 4'b0011;
    localparam logic [3:0] ST_POOL2 = 4'b0101;
    localparam logic [3:0] ST_POOL3 = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } pool_state_t;

    // Last valid index in each dimension of the pooled output (H == W).
    typedef struct packed {
        logic [5:0] h_last;
        logic [5:0] c_last;
    } pool_dims_t;

    function automatic logic pool_supported(input logic [3:0] code);
        return (code == ST_POOL1) || (code == ST_POOL2) || (code == ST_POOL3);
    endfunction

    function automatic pool_dims_t pool_dims(input logic [3:0] code);
        pool_dims_t d;
        d = '0;
        case (code)
            ST_POOL1: begin d.h_last = 6'd15; d.c_last = 6'd15; end
            ST_POOL2: begin d.h_last = 6'd7;  d.c_last = 6'd31; end
            ST_POOL3: begin d.h_last = 6'd3;  d.c_last = 6'd63; end
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pool_max4.sv
// Signed 4-input max; ReLU is fused after the max when POOL_RELU_EN is defined.
// Purely combinational, zero latency.
// No flow control; the engine qualifies the result.
module pool_max4 #(
    parameter int DAT_W = nn_pkg::DAT_W
) (
    input  logic signed [DAT_W-1:0] a,
    input  logic signed [DAT_W-1:0] b,
    input  logic signed [DAT_W-1:0] c,
    input  logic signed [DAT_W-1:0] d,
    output logic signed [DAT_W-1:0] y
);

    logic signed [DAT_W-1:0] max_ab;
    logic signed [DAT_W-1:0] max_cd;
    logic signed [DAT_W-1:0] max_all;

    assign max_ab  = (a > b) ? a : b;
    assign max_cd  = (c > d) ? c : d;
    assign max_all = (max_ab > max_cd) ? max_ab : max_cd;

`ifdef POOL_RELU_EN
    assign y = max_all[DAT_W-1] ? '0 : max_all;
`else
    assign y = max_all;
`endif

endmodule

// File: rtl/pool_engine.sv
// 2x2/stride-2 max-pool sequencer: row-pair reads from the pool buffer, one write per window.
// Latency: first write 4 cycles after start; done 1 cycle after the last write. POOL_RELU_EN fuses ReLU.
// No backpressure: buffers are always ready; one window issued every 2 cycles.
module pool_engine
    import nn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           layer,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [5:0]           rd_y,
    output logic [5:0]           rd_x,
    output logic [5:0]           rd_c,
    output logic                 rd_updown,
    input  logic [2*DAT_W-1:0]   rd_data,
    output logic                 wr_en,
    output logic [5:0]           wr_y,
    output logic [5:0]           wr_x,
    output logic [5:0]           wr_c,
    output logic [DAT_W-1:0]     wr_data
);

    pool_state_t state, state_nxt;
    logic [3:0]  layer_q, layer_nxt;
    logic        busy_nxt, done_nxt, rd_en_nxt, updown_nxt;
    logic [5:0]  y_nxt, x_nxt, c_nxt;
    pool_dims_t  dims;
    logic        last_win;

    assign dims     = pool_dims(layer_q);
    assign last_win = (rd_y == dims.h_last) && (rd_x == dims.h_last) && (rd_c == dims.c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            layer_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_updown <= 1'b0;
            rd_y      <= '0;
            rd_x      <= '0;
            rd_c      <= '0;
        end else begin
            state     <= state_nxt;
            layer_q   <= layer_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rd_en     <= rd_en_nxt;
            rd_updown <= updown_nxt;
            rd_y      <= y_nxt;
            rd_x      <= x_nxt;
            rd_c      <= c_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        layer_nxt  = layer_q;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        rd_en_nxt  = 1'b0;
        updown_nxt = 1'b0;
        y_nxt      = rd_y;
        x_nxt      = rd_x;
        c_nxt      = rd_c;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (pool_supported(layer)) begin
                        state_nxt = S_RUN;
                        layer_nxt = layer;
                        busy_nxt  = 1'b1;
                        rd_en_nxt = 1'b1;
                        y_nxt     = '0;
                        x_nxt     = '0;
                        c_nxt     = '0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                rd_en_nxt = 1'b1;
                if (!rd_updown) begin
                    updown_nxt = 1'b1;
                end else if (last_win) begin
                    state_nxt = S_DRAIN;
                    rd_en_nxt = 1'b0;
                end else if (rd_x != dims.h_last) begin
                    x_nxt = rd_x + 6'd1;
                end else begin
                    x_nxt = '0;
                    if (rd_y != dims.h_last) begin
                        y_nxt = rd_y + 6'd1;
                    end else begin
                        y_nxt = '0;
                        c_nxt = rd_c + 6'd1;
                    end
                end
            end
            S_DRAIN: begin
                // The first DRAIN cycle never carries a write (it follows an A read),
                // so the first wr_en seen here is the final window.
                if (wr_en) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    logic               a_vld_d, b_vld_d;
    logic [5:0]         y_d, x_d, c_d;
    logic [2*DAT_W-1:0] upper_q;
    logic [DAT_W-1:0]   max_w;

    pool_max4 #(.DAT_W(DAT_W)) u_max4 (
        .a (upper_q[DAT_W-1:0]),
        .b (upper_q[2*DAT_W-1:DAT_W]),
        .c (rd_data[DAT_W-1:0]),
        .d (rd_data[2*DAT_W-1:DAT_W]),
        .y (max_w)
    );

    // Read data lags the request by one cycle, so qualifiers and coordinates follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_d <= 1'b0;
            b_vld_d <= 1'b0;
            y_d     <= '0;
            x_d     <= '0;
            c_d     <= '0;
            upper_q <= '0;
            wr_en   <= 1'b0;
            wr_y    <= '0;
            wr_x    <= '0;
            wr_c    <= '0;
            wr_data <= '0;
        end else begin
            a_vld_d <= rd_en & ~rd_updown;
            b_vld_d <= rd_en & rd_updown;
            y_d     <= rd_y;
            x_d     <= rd_x;
            c_d     <= rd_c;
            wr_en   <= b_vld_d;
            if (a_vld_d) begin
                upper_q <= rd_data;
            end
            if (b_vld_d) begin
                wr_y    <= y_d;
                wr_x    <= x_d;
                wr_c    <= c_d;
                wr_data <= max_w;
            end
        end
    end

endmodule

// File: tb/tb_pool_engine.sv
// Directed bench for pool_engine: behavioural pool-buffer read port plus a write monitor
// checking count, order, timing and pooled values against a golden 2x2 max.
module tb_pool_engine;
    import nn_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [3:0]           layer;
    logic                 busy, done, rd_en, rd_updown, wr_en;
    logic [5:0]           rd_y, rd_x, rd_c, wr_y, wr_x, wr_c;
    logic [2*DAT_W-1:0]   rd_data = '0;
    logic [DAT_W-1:0]     wr_data;

    always #5 clk = ~clk;

    pool_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer(layer),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_y(rd_y), .rd_x(rd_x), .rd_c(rd_c),
        .rd_updown(rd_updown), .rd_data(rd_data),
        .wr_en(wr_en), .wr_y(wr_y), .wr_x(wr_x), .wr_c(wr_c), .wr_data(wr_data)
    );

    int mode = 0;

    function automatic logic [21:0] pix(input int m, input int row, input int col, input int ch);
        int v;
        int idx;
        idx = (row % 2) * 2 + (col % 2);
        v = 0;
        case (m)
            0: v = (((row * 13 + col * 7 + ch * 29) % 61) - 30) * 1000;
            1: case (idx) 0: v = -5; 1: v = -3; 2: v = -100; default: v = -2; endcase
            default: case (idx) 0: v = 32'h1FFFFF; 1: v = -2097152; 2: v = 0; default: v = 1; endcase
        endcase
        return v[21:0];
    endfunction

    function automatic int sx(input logic [21:0] p);
        return int'($signed(p));
    endfunction

    function automatic int golden(input int y, input int x, input int ch);
        int mx;
        int v;
        mx = sx(pix(mode, 2 * y, 2 * x, ch));
        for (int k = 1; k < 4; k++) begin
            v = sx(pix(mode, 2 * y + k / 2, 2 * x + k % 2, ch));
            if (v > mx) mx = v;
        end
`ifdef POOL_RELU_EN
        if (mx < 0) mx = 0;
`endif
        return mx;
    endfunction

    // Feature buffer read port: one-cycle registered latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= {pix(mode, 2 * int'(rd_y) + int'(rd_updown), 2 * int'(rd_x) + 1, int'(rd_c)),
                        pix(mode, 2 * int'(rd_y) + int'(rd_updown), 2 * int'(rd_x),     int'(rd_c))};
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    int wr_cnt, data_bad, ord_bad, done_cnt, done_busy;
    int first_wr_cyc, last_wr_cyc, done_cyc, s_cyc;
    int ey, ex, ec, hh;
    int any_rd, any_wr, any_busy;
    logic [21:0] first_dat;
    logic [17:0] last_coord;
    logic        busy_after;

    task automatic clr(input int h);
        wr_cnt = 0; data_bad = 0; ord_bad = 0; done_cnt = 0; done_busy = 0;
        first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
        ey = 0; ex = 0; ec = 0; hh = h;
        any_rd = 0; any_wr = 0; any_busy = 0;
        first_dat = '0; last_coord = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (wr_en) begin
            if (wr_cnt == 0) begin
                first_wr_cyc = cyc;
                first_dat    = wr_data;
            end
            last_wr_cyc = cyc;
            last_coord  = {wr_y, wr_x, wr_c};
            if (wr_y !== 6'(ey) || wr_x !== 6'(ex) || wr_c !== 6'(ec)) ord_bad++;
            if (sx(wr_data) != golden(int'(wr_y), int'(wr_x), int'(wr_c))) data_bad++;
            wr_cnt++;
            ex++;
            if (ex == hh) begin
                ex = 0; ey++;
                if (ey == hh) begin ey = 0; ec++; end
            end
        end
        if (rd_en) any_rd++;
        if (wr_en) any_wr++;
        if (busy)  any_busy++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) done_busy++;
        end
    endtask

    task automatic run_start(input logic [3:0] code);
        layer = code;
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        busy_after = busy;
    endtask

    task automatic wait_done(input int limit);
        for (int n = 0; n < limit && done_cnt == 0; n++) tick();
        tick();
    endtask

    localparam logic [21:0] EXP_NEG = 22'h3FFFFE;
    localparam logic [21:0] EXP_POS = 22'h1FFFFF;

    initial begin
        rst_n = 1'b0; start = 1'b0; layer = 4'd0;
        clr(16);
        repeat (3) tick();
        check("rst_busy",    busy,    1'b0);
        check("rst_done",    done,    1'b0);
        check("rst_rd_en",   rd_en,   1'b0);
        check("rst_wr_en",   wr_en,   1'b0);
        check("rst_outs",    {rd_y, rd_x, rd_c, rd_updown, wr_y, wr_x, wr_c, wr_data}, '0);
        rst_n = 1'b1;
        tick();

        // POOL1 ramp: full count, latency, order, values
        mode = 0; clr(16);
        run_start(ST_POOL1);
        check("p1_busy_after_start", busy_after, 1'b1);
        wait_done(12000);
        check("p1_done_cnt",    done_cnt, 1);
        check("p1_writes",      wr_cnt, 4096);
        check("p1_first_lat",   first_wr_cyc - s_cyc, 4);
        check("p1_done_lat",    done_cyc - last_wr_cyc, 1);
        check("p1_data_bad",    data_bad, 0);
        check("p1_order_bad",   ord_bad, 0);
        check("p1_busy_at_done", done_busy, 0);
        check("p1_last_coord",  last_coord, {6'd15, 6'd15, 6'd15});

        // All-negative window
        mode = 1; clr(4);
        run_start(ST_POOL3);
        wait_done(4000);
`ifdef POOL_RELU_EN
        check("neg_window", first_dat, 22'h0);
`else
        check("neg_window", first_dat, EXP_NEG);
`endif
        check("neg_data_bad", data_bad, 0);
        check("neg_writes",   wr_cnt, 1024);

        // Extremes: largest positive beats most negative
        mode = 2; clr(4);
        run_start(ST_POOL3);
        wait_done(4000);
        check("ext_window",   first_dat, EXP_POS);
        check("ext_data_bad", data_bad, 0);

        // POOL3 with an ignored restart mid-run
        mode = 0; clr(4);
        run_start(ST_POOL3);
        for (int n = 0; n < 3000 && wr_cnt < 300; n++) tick();
        check("p3_reached_300", wr_cnt >= 300, 1'b1);
        layer = ST_POOL1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4000);
        repeat (5) tick();
        check("p3_writes",     wr_cnt, 1024);
        check("p3_last_coord", last_coord, {6'd3, 6'd3, 6'd63});
        check("p3_order_bad",  ord_bad, 0);
        check("p3_data_bad",   data_bad, 0);
        check("p3_done_cnt",   done_cnt, 1);

        // Unsupported code
        clr(4);
        run_start(4'b0010);
        check("bad_code_done", done, 1'b1);
        repeat (6) tick();
        check("bad_code_rd",   any_rd, 0);
        check("bad_code_wr",   any_wr, 0);
        check("bad_code_busy", any_busy, 0);
        check("bad_code_done_cnt", done_cnt, 1);

        // POOL2 interrupted by reset at write #100, then a clean rerun
        mode = 0; clr(8);
        run_start(ST_POOL2);
        for (int n = 0; n < 3000 && wr_cnt < 100; n++) tick();
        check("p2_reached_100", wr_cnt, 100);
        rst_n = 1'b0;
        #1;
        check("p2_reset_outs", {busy, done, rd_en, rd_updown, wr_en, rd_y, rd_x, rd_c,
                                wr_y, wr_x, wr_c, wr_data}, '0);
        tick();
        tick();
        check("p2_no_write_in_reset", wr_cnt, 100);
        rst_n = 1'b1;
        tick();
        clr(8);
        run_start(ST_POOL2);
        wait_done(6000);
        check("p2_writes",    wr_cnt, 2048);
        check("p2_data_bad",  data_bad, 0);
        check("p2_order_bad", ord_bad, 0);
        check("p2_done_cnt",  done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
